// File: rtl/floppy_multi_if.sv
// Controller-side bus of the multi-drive virtual floppy: drive control in, disk timing out.
interface floppy_multi_if #(
  parameter int NUM_DRIVES = 4
);
  logic [NUM_DRIVES-1:0] drive_sel;
  logic                  motor_on;
  logic                  step_in;
  logic                  step_out;
  logic [4:0]            step_ms;
  logic [1:0]            density;
  logic [4:0]            spt;
  logic                  sector_base;
  logic [10:0]           sector_len;
  logic [9:0]            sector_gap_len;
  logic [NUM_DRIVES-1:0] disk_present;
  logic                  byte_en;
  logic [7:0]            track;
  logic                  track0;
  logic [4:0]            sector;
  logic                  sector_hdr;
  logic                  sector_data;
  logic                  index;
  logic                  ready;

  modport master (
    output drive_sel, motor_on, step_in, step_out, step_ms, density, spt,
           sector_base, sector_len, sector_gap_len, disk_present,
    input  byte_en, track, track0, sector, sector_hdr, sector_data, index, ready
  );

  modport slave (
    input  drive_sel, motor_on, step_in, step_out, step_ms, density, spt,
           sector_base, sector_len, sector_gap_len, disk_present,
    output byte_en, track, track0, sector, sector_hdr, sector_data, index, ready
  );
endinterface

// File: rtl/floppy_multi.sv
// Virtual floppy mechanism: NUM_DRIVES heads sharing one spindle, byte clock,
// index pulse and sector GAP/HDR/DATA framer.
module floppy_multi #(
  parameter int SYS_CLK        = 42578000,
  parameter int NUM_DRIVES     = 4,
  parameter int TRACKS         = 80,
  parameter int SPINUP_MS      = 250,
  parameter int INDEX_MS       = 4,
  parameter int SECTOR_HDR_LEN = 6
) (
  input  logic          clk,
  input  logic          reset,
  floppy_multi_if.slave bus
);

  localparam int MS_DIV = SYS_CLK / 1000;
  localparam int MSW    = $clog2(MS_DIV);
  localparam int SPW    = $clog2(SPINUP_MS + 1);
  localparam int IXW    = $clog2(INDEX_MS + 1);
  localparam int DW     = (NUM_DRIVES > 1) ? $clog2(NUM_DRIVES) : 1;

  localparam logic [MSW-1:0] MS_LAST = MSW'(MS_DIV - 1);
  localparam logic [MSW-1:0] MS_ONE  = MSW'(1);
  localparam logic [SPW-1:0] SP_FULL = SPW'(SPINUP_MS);
  localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
  localparam logic [IXW-1:0] IX_LOAD = IXW'(INDEX_MS);
  localparam logic [IXW-1:0] IX_ONE  = IXW'(1);
  localparam logic [31:0]    SYS32   = 32'(SYS_CLK);
  localparam logic [32:0]    SYS33   = 33'(SYS_CLK);
  localparam logic [10:0]    HDR_M1  = 11'(SECTOR_HDR_LEN - 1);
  localparam logic [7:0]     TRK_MAX = 8'(TRACKS - 1);

  localparam logic [1:0] ST_GAP  = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [MSW-1:0] ms_cnt_q, ms_cnt_d;
  logic [SPW-1:0] spin_q, spin_d;
  logic [31:0]    acc_q, acc_d;
  logic           byte_en_q, byte_en_d;
  logic [13:0]    byte_cnt_q, byte_cnt_d;
  logic           index_q, index_d;
  logic [IXW-1:0] idx_cnt_q, idx_cnt_d;
  logic [1:0]     st_q, st_d;
  logic [10:0]    cnt_q, cnt_d;
  logic [4:0]     sector_q, sector_d;
  logic           hdr_q, hdr_d, data_q, data_d;
  logic [7:0]     trk_q [NUM_DRIVES];
  logic [7:0]     trk_d [NUM_DRIVES];
  logic           sin_q, sin_prev_q, sout_q, sout_prev_q;
  logic [4:0]     busy_q, busy_d;
  logic [7:0]     track_q, track_d;
  logic           track0_q, track0_d, ready_q, ready_d;

  logic [3:0]    nsel;
  logic [DW-1:0] act_idx;
  logic          active, ms_tick, rotating, idx_start, last_sec;
  logic          e_in, e_out, step_ok;
  logic [31:0]   inc;
  logic [13:0]   bpt;
  logic [32:0]   sum;
  logic [4:0]    next_sec;
  logic [10:0]   gap_m1;
  logic [7:0]    cur_trk;

  assign ms_tick  = (ms_cnt_q == MS_LAST);
  assign rotating = (spin_q != '0);
  assign e_in     = sin_q & ~sin_prev_q;
  assign e_out    = sout_q & ~sout_prev_q;
  assign gap_m1   = {1'b0, bus.sector_gap_len} - 11'd1;

  // Decode the one-hot drive select; anything else means no drive is active.
  always_comb begin
    nsel    = 4'd0;
    act_idx = '0;
    for (int i = 0; i < NUM_DRIVES; i++) begin
      nsel    = nsel + {3'd0, bus.drive_sel[i]};
      act_idx = bus.drive_sel[i] ? DW'(i) : act_idx;
    end
    active  = (nsel == 4'd1);
    cur_trk = trk_q[act_idx];
  end

  // Shared spindle: ms prescaler, spin ramp, byte phase accumulator, revolution and index.
  always_comb begin
    ms_cnt_d = ms_tick ? '0 : ms_cnt_q + MS_ONE;
    if (!ms_tick) begin
      spin_d = spin_q;
    end else if (bus.motor_on && active) begin
      spin_d = (spin_q == SP_FULL) ? spin_q : spin_q + SP_ONE;
    end else begin
      spin_d = (spin_q == '0) ? spin_q : spin_q - SP_ONE;
    end
    case (bus.density)
      2'd0:    begin inc = 32'd15625; bpt = 14'd3125;  end
      2'd1:    begin inc = 32'd31250; bpt = 14'd6250;  end
      default: begin inc = 32'd62500; bpt = 14'd12500; end
    endcase
    sum = {1'b0, acc_q} + {1'b0, inc};
    if (!rotating) begin
      acc_d     = 32'd0;
      byte_en_d = 1'b0;
    end else if (sum >= SYS33) begin
      acc_d     = sum[31:0] - SYS32;
      byte_en_d = 1'b1;
    end else begin
      acc_d     = sum[31:0];
      byte_en_d = 1'b0;
    end
    // >= rather than == so a density drop mid-revolution still wraps.
    idx_start  = byte_en_q && (byte_cnt_q >= bpt - 14'd1);
    byte_cnt_d = idx_start ? 14'd0 : (byte_en_q ? byte_cnt_q + 14'd1 : byte_cnt_q);
    if (idx_start) begin
      index_d   = 1'b1;
      idx_cnt_d = IX_LOAD;
    end else if (ms_tick && index_q) begin
      index_d   = (idx_cnt_q > IX_ONE);
      idx_cnt_d = idx_cnt_q - IX_ONE;
    end else begin
      index_d   = index_q;
      idx_cnt_d = idx_cnt_q;
    end
  end

  // Sector framer, advanced once per disk byte and resynchronised by the index.
  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    sector_d = sector_q;
    last_sec = ({1'b0, sector_q} + 6'd1) >= ({5'd0, bus.sector_base} + {1'b0, bus.spt});
    next_sec = last_sec ? {4'd0, bus.sector_base} : sector_q + 5'd1;
    if (!byte_en_q) begin
      cnt_d = cnt_q;
    end else if (idx_start) begin
      st_d     = ST_GAP;
      cnt_d    = gap_m1;
      sector_d = {4'd0, bus.sector_base};
    end else if (cnt_q != 11'd0) begin
      cnt_d = cnt_q - 11'd1;
    end else begin
      case (st_q)
        ST_GAP:  begin st_d = ST_HDR;  cnt_d = HDR_M1; end
        ST_HDR:  begin st_d = ST_DATA; cnt_d = bus.sector_len - 11'd1; end
        ST_DATA: begin st_d = ST_GAP;  cnt_d = gap_m1; sector_d = next_sec; end
        default: begin st_d = ST_GAP;  cnt_d = gap_m1; end
      endcase
    end
    hdr_d  = (st_d == ST_HDR);
    data_d = (st_d == ST_DATA);
  end

  // Head stepping with settle lockout, plus the per-drive status outputs.
  always_comb begin
    trk_d   = trk_q;
    step_ok = active && (busy_q == 5'd0) && (e_in ^ e_out);
    if (step_ok) begin
      busy_d = bus.step_ms;
      if (e_in) begin
        trk_d[act_idx] = (cur_trk == 8'd0) ? cur_trk : cur_trk - 8'd1;
      end else begin
        trk_d[act_idx] = (cur_trk >= TRK_MAX) ? cur_trk : cur_trk + 8'd1;
      end
    end else if (ms_tick && (busy_q != 5'd0)) begin
      busy_d = busy_q - 5'd1;
    end else begin
      busy_d = busy_q;
    end
    track_d  = active ? cur_trk : 8'd0;
    track0_d = active && (cur_trk == 8'd0);
    ready_d  = active && bus.disk_present[act_idx] && (spin_q == SP_FULL) && (busy_q == 5'd0);
  end

  // State registers; reset clears everything at once, including the outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_cnt_q    <= '0;
      spin_q      <= '0;
      acc_q       <= 32'd0;
      byte_en_q   <= 1'b0;
      byte_cnt_q  <= 14'd0;
      index_q     <= 1'b0;
      idx_cnt_q   <= '0;
      st_q        <= ST_GAP;
      cnt_q       <= 11'd0;
      sector_q    <= 5'd0;
      hdr_q       <= 1'b0;
      data_q      <= 1'b0;
      for (int i = 0; i < NUM_DRIVES; i++) trk_q[i] <= 8'd0;
      sin_q       <= 1'b0;
      sin_prev_q  <= 1'b0;
      sout_q      <= 1'b0;
      sout_prev_q <= 1'b0;
      busy_q      <= 5'd0;
      track_q     <= 8'd0;
      track0_q    <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      ms_cnt_q    <= ms_cnt_d;
      spin_q      <= spin_d;
      acc_q       <= acc_d;
      byte_en_q   <= byte_en_d;
      byte_cnt_q  <= byte_cnt_d;
      index_q     <= index_d;
      idx_cnt_q   <= idx_cnt_d;
      st_q        <= st_d;
      cnt_q       <= cnt_d;
      sector_q    <= sector_d;
      hdr_q       <= hdr_d;
      data_q      <= data_d;
      trk_q       <= trk_d;
      sin_q       <= bus.step_in;
      sin_prev_q  <= sin_q;
      sout_q      <= bus.step_out;
      sout_prev_q <= sout_q;
      busy_q      <= busy_d;
      track_q     <= track_d;
      track0_q    <= track0_d;
      ready_q     <= ready_d;
    end
  end

  assign bus.byte_en     = byte_en_q;
  assign bus.track       = track_q;
  assign bus.track0      = track0_q;
  assign bus.sector      = sector_q;
  assign bus.sector_hdr  = hdr_q;
  assign bus.sector_data = data_q;
  assign bus.index       = index_q;
  assign bus.ready       = ready_q;

endmodule

// File: tb/tb_floppy_multi.sv
// Bench for floppy_multi. SYS_CLK is scaled to 125 kHz (1 ms = 125 clk, DD byte every
// 4 clk) and spin-up to 100 ms so a full revolution fits a short run.
module tb_floppy_multi;
  localparam int SYS_CLK  = 125000;
  localparam int ND       = 4;
  localparam int SPIN     = 100;
  localparam int MS       = SYS_CLK / 1000;
  localparam int BYTE_CLK = SYS_CLK / 31250;
  localparam int REV_CLK  = 6250 * BYTE_CLK;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc_now = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_q[$];
  int   model_trk [ND];

  floppy_multi_if #(.NUM_DRIVES(ND)) bus ();

  floppy_multi #(
    .SYS_CLK(SYS_CLK), .NUM_DRIVES(ND), .TRACKS(80),
    .SPINUP_MS(SPIN), .INDEX_MS(4), .SECTOR_HDR_LEN(6)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  // Free-running cycle counter used as the bench time base.
  always @(posedge clk) cyc_now <= cyc_now + 1;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag, input int obs);
    int e;
    e = -1;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    check_eq(tag, obs, e);
  endtask

  task automatic wait_until(input int t);
    while (cyc_now < t) @(negedge clk);
  endtask

  function automatic int outs();
    return int'({13'd0, bus.byte_en, bus.index, bus.ready, bus.track0,
                 bus.sector_hdr, bus.sector_data, bus.track, bus.sector});
  endfunction

  function automatic int sel_idx();
    int n = 0;
    int k = -1;
    for (int i = 0; i < ND; i++) begin
      if (bus.drive_sel[i]) begin
        n++;
        k = i;
      end
    end
    return (n == 1) ? k : -1;
  endfunction

  // Pulse one step line, update the head model, then compare the reported track.
  task automatic step(input string tag, input bit dir_out, input bit allow, output int t0);
    int k;
    k = sel_idx();
    @(negedge clk);
    t0 = cyc_now;
    if (dir_out) bus.step_out = 1'b1;
    else         bus.step_in  = 1'b1;
    repeat (3) @(negedge clk);
    bus.step_out = 1'b0;
    bus.step_in  = 1'b0;
    if (allow && k >= 0) begin
      if (dir_out) model_trk[k] = (model_trk[k] >= 79) ? 79 : model_trk[k] + 1;
      else         model_trk[k] = (model_trk[k] == 0) ? 0 : model_trk[k] - 1;
    end
    exp_q.push_back((k >= 0) ? model_trk[k] : 0);
    @(negedge clk);
    sb_check(tag, int'(bus.track));
  endtask

  task automatic measure_ready(input string tag);
    int c = 0;
    while (!bus.ready && c < 3 * SPIN * MS) begin
      @(negedge clk);
      c++;
    end
    check_eq(tag, (c + MS / 2) / MS, SPIN);
  endtask

  initial begin
    int t0, t1, c, idx_len, bytes, hdrs, hdr_bytes, data_bytes;
    bit idx_open, prev_hdr;
    for (int i = 0; i < ND; i++) model_trk[i] = 0;
    bus.drive_sel      = 4'b0001;
    bus.disk_present   = 4'b1111;
    bus.motor_on       = 1'b1;
    bus.step_in        = 1'b0;
    bus.step_out       = 1'b0;
    bus.step_ms        = 5'd6;
    bus.density        = 2'd1;
    bus.spt            = 5'd10;
    bus.sector_base    = 1'b1;
    bus.sector_len     = 11'd256;
    bus.sector_gap_len = 10'd363;
    repeat (3) @(negedge clk);

    // 1: reset state, spin-up time, byte clock
    check_eq("reset_outputs", outs(), 0);
    reset = 1'b0;
    measure_ready("spinup_ms");
    check_eq("track0_after_reset", int'(bus.track0), 1);
    c = 0;
    while (!bus.byte_en && c < 1000) begin @(negedge clk); c++; end
    c = 0;
    do begin @(negedge clk); c++; end while (!bus.byte_en && c < 1000);
    check_eq("byte_period", c, BYTE_CLK);
    @(negedge clk);
    check_eq("byte_pulse_width", int'(bus.byte_en), 0);

    // 2: three steps 10 ms apart with 6 ms settle, one early step locked out
    for (int k = 0; k < 3; k++) begin
      step("step_out_track", 1'b1, 1'b1, t0);
      check_eq("busy_after_step", int'(bus.ready), 0);
      if (k == 0) begin
        wait_until(t0 + 2 * MS);
        step("step_locked", 1'b1, 1'b0, t1);
      end
      wait_until(t0 + 4 * MS);
      check_eq("busy_at_4ms", int'(bus.ready), 0);
      wait_until(t0 + 6 * MS + 10);
      check_eq("ready_after_settle", int'(bus.ready), 1);
      wait_until(t0 + 10 * MS);
    end

    // 3: drive 0 to track 5, swap drives and back
    bus.step_ms = 5'd0;
    step("step_to_4", 1'b1, 1'b1, t0);
    step("step_to_5", 1'b1, 1'b1, t0);
    check_eq("no_busy_step_ms0", int'(bus.ready), 1);
    bus.drive_sel = 4'b0010;
    repeat (3) @(negedge clk);
    exp_q.push_back(model_trk[1]);
    sb_check("drive1_track", int'(bus.track));
    check_eq("drive1_track0", int'(bus.track0), 1);
    bus.drive_sel = 4'b0001;
    repeat (3) @(negedge clk);
    exp_q.push_back(model_trk[0]);
    sb_check("drive0_track", int'(bus.track));
    check_eq("drive0_track0", int'(bus.track0), 0);

    // 5: saturation at both ends, invalid select
    bus.drive_sel = 4'b0010;
    bus.step_ms   = 5'd3;
    repeat (3) @(negedge clk);
    step("step_in_at_0", 1'b0, 1'b1, t0);
    check_eq("sat_in_loads_busy", int'(bus.ready), 0);
    wait_until(t0 + 4 * MS + 10);
    check_eq("ready_after_sat_busy", int'(bus.ready), 1);
    bus.step_ms = 5'd0;
    for (int k = 0; k < 82; k++) step("step_out_sat", 1'b1, 1'b1, t0);
    check_eq("track0_at_79", int'(bus.track0), 0);
    bus.drive_sel = 4'b0011;
    repeat (3) @(negedge clk);
    check_eq("multi_sel_ready", int'(bus.ready), 0);
    check_eq("multi_sel_track0", int'(bus.track0), 0);
    step("multi_sel_step", 1'b0, 1'b0, t0);
    bus.drive_sel = 4'b0010;
    repeat (3) @(negedge clk);
    exp_q.push_back(model_trk[1]);
    sb_check("track_kept_79", int'(bus.track));

    // 4: sector framing over one revolution
    c = 0;
    while (!bus.index && c < 2 * REV_CLK) begin @(negedge clk); c++; end
    check_eq("index_found", int'(bus.index), 1);
    exp_q.delete();
    for (int s = 0; s < 11; s++) exp_q.push_back((s % 10) + 1);
    idx_len = 0; idx_open = 1'b1; bytes = 0; hdrs = 0;
    hdr_bytes = 0; data_bytes = 0; prev_hdr = 1'b0; c = 0;
    while (hdrs < 11 && c < 2 * REV_CLK) begin
      if (idx_open && bus.index) idx_len++;
      else idx_open = 1'b0;
      if (bus.sector_hdr && !prev_hdr) begin
        if (hdrs == 0) check_eq("hdr_after_index", bytes, 363);
        sb_check("sector_seq", int'(bus.sector));
        hdrs++;
      end
      if (hdrs == 1 && bus.sector_hdr && bus.byte_en) hdr_bytes++;
      if (hdrs == 1 && bus.sector_data && bus.byte_en) data_bytes++;
      if (hdrs == 0 && bus.byte_en) bytes++;
      prev_hdr = bus.sector_hdr;
      @(negedge clk);
      c++;
    end
    check_eq("header_count", hdrs, 11);
    check_eq("index_ms", (idx_len + MS - 1) / MS, 4);
    check_eq("hdr_bytes", hdr_bytes, 6);
    check_eq("data_bytes", data_bytes, 256);
    exp_q.delete();

    // 6: asynchronous reset in the middle of a settle period
    bus.drive_sel = 4'b0001;
    bus.step_ms   = 5'd6;
    c = 0;
    while (!bus.ready && c < 5 * MS) begin @(negedge clk); c++; end
    step("pre_reset_step", 1'b1, 1'b1, t0);
    wait_until(t0 + MS);
    check_eq("mid_step_ready", int'(bus.ready), 0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_eq("async_reset_outputs", outs(), 0);
    for (int i = 0; i < ND; i++) model_trk[i] = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    measure_ready("respin_ms");
    exp_q.push_back(model_trk[0]);
    sb_check("track_after_reset", int'(bus.track));
    check_eq("track0_after_respin", int'(bus.track0), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
